// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: drives register-file read addresses, forwards results from
// EX/MEM/WB to resolve RAW hazards, inserts a single bubble on load-use hazards and
// registers control plus operands into the OF/EX pipeline register. Also keeps a
// saturating count of cycles in which decode was held.
module operand_fetch_stage #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  // Decode side
  input  logic                    id_valid,
  input  logic [OPCODE_WIDTH-1:0] id_opcode,
  input  logic [ADDR_WIDTH-1:0]   id_rs0,
  input  logic [ADDR_WIDTH-1:0]   id_rs1,
  input  logic                    id_use_rs0,
  input  logic                    id_use_rs1,
  input  logic [ADDR_WIDTH-1:0]   id_rd,
  input  logic                    id_reg_write,
  input  logic                    id_mem_read,
  output logic                    id_stall,
  // Register file read ports
  output logic [ADDR_WIDTH-1:0]   rf_read0_addr,
  output logic [ADDR_WIDTH-1:0]   rf_read1_addr,
  input  logic [DATA_WIDTH-1:0]   rf_data0,
  input  logic [DATA_WIDTH-1:0]   rf_data1,
  // Forwarding sources
  input  logic [DATA_WIDTH-1:0]   ex_result,
  input  logic                    mem_fwd_en,
  input  logic [ADDR_WIDTH-1:0]   mem_fwd_rd,
  input  logic [DATA_WIDTH-1:0]   mem_fwd_data,
  input  logic                    wb_write_en,
  input  logic [ADDR_WIDTH-1:0]   wb_write_addr,
  input  logic [DATA_WIDTH-1:0]   wb_write_data,
  // Pipeline control
  input  logic                    ex_stall,
  input  logic                    flush,
  // OF/EX pipeline register
  output logic                    of_valid,
  output logic [OPCODE_WIDTH-1:0] of_opcode,
  output logic [ADDR_WIDTH-1:0]   of_rd,
  output logic                    of_reg_write,
  output logic                    of_mem_read,
  output logic [DATA_WIDTH-1:0]   of_operand0,
  output logic [DATA_WIDTH-1:0]   of_operand1,
  output logic [STALL_CNT_W-1:0]  stall_count
);

  localparam logic [ADDR_WIDTH-1:0]  ZeroIdx  = '0;
  localparam logic [STALL_CNT_W-1:0] CntMax   = '1;
  localparam logic [STALL_CNT_W-1:0] CntOne   = STALL_CNT_W'(1);

  // Pipeline register state
  logic                    valid_q,     valid_d;
  logic [OPCODE_WIDTH-1:0] opcode_q,    opcode_d;
  logic [ADDR_WIDTH-1:0]   rd_q,        rd_d;
  logic                    reg_write_q, reg_write_d;
  logic                    mem_read_q,  mem_read_d;
  logic [DATA_WIDTH-1:0]   operand0_q,  operand0_d;
  logic [DATA_WIDTH-1:0]   operand1_q,  operand1_d;
  logic [STALL_CNT_W-1:0]  cnt_q,       cnt_d;

  // Forwarding hit terms; EX hit is gated by valid so a bubble never forwards
  logic ex_hit0, ex_hit1;
  logic mem_hit0, mem_hit1;
  logic wb_hit0, wb_hit1;
  logic [DATA_WIDTH-1:0] sel_operand0, sel_operand1;
  logic load_use;
  logic ex_writes;

  assign rf_read0_addr = id_rs0;
  assign rf_read1_addr = id_rs1;

  assign ex_writes = valid_q & reg_write_q;

  // Source-match terms for each forwarding path
  always_comb begin
    ex_hit0  = ex_writes & (rd_q == id_rs0);
    ex_hit1  = ex_writes & (rd_q == id_rs1);
    mem_hit0 = mem_fwd_en & (mem_fwd_rd == id_rs0);
    mem_hit1 = mem_fwd_en & (mem_fwd_rd == id_rs1);
    wb_hit0  = wb_write_en & (wb_write_addr == id_rs0);
    wb_hit1  = wb_write_en & (wb_write_addr == id_rs1);
  end

  // Operand 0 select: r0, then youngest producer first, then register file
  always_comb begin
    sel_operand0 = rf_data0;
    if (id_rs0 == ZeroIdx) begin
      sel_operand0 = '0;
    end else if (ex_hit0) begin
      sel_operand0 = ex_result;
    end else if (mem_hit0) begin
      sel_operand0 = mem_fwd_data;
    end else if (wb_hit0) begin
      // RF write lands on the coming edge, so the read port still shows the old value
      sel_operand0 = wb_write_data;
    end
  end

  // Operand 1 select, same priority as operand 0
  always_comb begin
    sel_operand1 = rf_data1;
    if (id_rs1 == ZeroIdx) begin
      sel_operand1 = '0;
    end else if (ex_hit1) begin
      sel_operand1 = ex_result;
    end else if (mem_hit1) begin
      sel_operand1 = mem_fwd_data;
    end else if (wb_hit1) begin
      sel_operand1 = wb_write_data;
    end
  end

  // Load in EX cannot forward yet; a consumer in decode must wait one cycle
  always_comb begin
    load_use = id_valid & valid_q & mem_read_q & (rd_q != ZeroIdx) &
               ((id_use_rs0 & (id_rs0 == rd_q)) | (id_use_rs1 & (id_rs1 == rd_q)));
    id_stall = ~flush & (ex_stall | load_use);
  end

  // Next-state for the OF/EX register: flush > ex_stall > load-use bubble > capture
  always_comb begin
    valid_d     = valid_q;
    opcode_d    = opcode_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    operand0_d  = operand0_q;
    operand1_d  = operand1_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (ex_stall) begin
      valid_d = valid_q;
    end else if (load_use) begin
      valid_d = 1'b0;
    end else begin
      valid_d     = id_valid;
      opcode_d    = id_opcode;
      rd_d        = id_rd;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      operand0_d  = sel_operand0;
      operand1_d  = sel_operand1;
    end
  end

  // Stall-cycle counter saturates at all-ones instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (id_stall && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // OF/EX pipeline register and stall counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      operand0_q  <= '0;
      operand1_q  <= '0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      opcode_q    <= opcode_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      operand0_q  <= operand0_d;
      operand1_q  <= operand1_d;
      cnt_q       <= cnt_d;
    end
  end

  assign of_valid     = valid_q;
  assign of_opcode    = opcode_q;
  assign of_rd        = rd_q;
  assign of_reg_write = reg_write_q;
  assign of_mem_read  = mem_read_q;
  assign of_operand0  = operand0_q;
  assign of_operand1  = operand1_q;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios followed by random traffic, all
// checked against a behavioural model of the pipeline register and stall counter.
module tb_operand_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs0, id_use_rs1, id_reg_write, id_mem_read;
  logic [3:0]  id_opcode;
  logic [2:0]  id_rs0, id_rs1, id_rd, mem_fwd_rd, wb_write_addr;
  logic [15:0] rf_data0, rf_data1, ex_result, mem_fwd_data, wb_write_data;
  logic        mem_fwd_en, wb_write_en, ex_stall, flush;

  logic        id_stall, of_valid, of_reg_write, of_mem_read;
  logic [2:0]  rf_read0_addr, rf_read1_addr, of_rd;
  logic [3:0]  of_opcode;
  logic [15:0] of_operand0, of_operand1, stall_count;

  // Outputs of the narrow-counter instance (only its counter is checked)
  logic        s_id_stall, s_of_valid, s_of_reg_write, s_of_mem_read;
  logic [2:0]  s_rf_read0_addr, s_rf_read1_addr, s_of_rd;
  logic [3:0]  s_of_opcode;
  logic [15:0] s_of_operand0, s_of_operand1;
  logic [3:0]  s_stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic        m_valid, m_reg_write, m_mem_read;
  logic [3:0]  m_opcode;
  logic [2:0]  m_rd;
  logic [15:0] m_op0, m_op1;
  int          m_cnt, m_cnt_s;

  always #5 clock = ~clock;

  operand_fetch_stage dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs0(id_rs0), .id_rs1(id_rs1),
    .id_use_rs0(id_use_rs0), .id_use_rs1(id_use_rs1), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_stall(id_stall),
    .rf_read0_addr(rf_read0_addr), .rf_read1_addr(rf_read1_addr),
    .rf_data0(rf_data0), .rf_data1(rf_data1), .ex_result(ex_result),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_write_en(wb_write_en), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .ex_stall(ex_stall), .flush(flush),
    .of_valid(of_valid), .of_opcode(of_opcode), .of_rd(of_rd), .of_reg_write(of_reg_write),
    .of_mem_read(of_mem_read), .of_operand0(of_operand0), .of_operand1(of_operand1),
    .stall_count(stall_count)
  );

  operand_fetch_stage #(.STALL_CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs0(id_rs0), .id_rs1(id_rs1),
    .id_use_rs0(id_use_rs0), .id_use_rs1(id_use_rs1), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_stall(s_id_stall),
    .rf_read0_addr(s_rf_read0_addr), .rf_read1_addr(s_rf_read1_addr),
    .rf_data0(rf_data0), .rf_data1(rf_data1), .ex_result(ex_result),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_write_en(wb_write_en), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .ex_stall(ex_stall), .flush(flush),
    .of_valid(s_of_valid), .of_opcode(s_of_opcode), .of_rd(s_of_rd),
    .of_reg_write(s_of_reg_write), .of_mem_read(s_of_mem_read),
    .of_operand0(s_of_operand0), .of_operand1(s_of_operand1),
    .stall_count(s_stall_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value an instruction in decode should see for a source register
  function automatic logic [15:0] pick(input logic [2:0] idx, input logic [15:0] rf);
    if (idx == 3'd0) return 16'h0000;
    if (m_valid && m_reg_write && m_rd == idx) return ex_result;
    if (mem_fwd_en && mem_fwd_rd == idx) return mem_fwd_data;
    if (wb_write_en && wb_write_addr == idx) return wb_write_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_reg_write = 0; m_mem_read = 0; m_opcode = 0; m_rd = 0;
    m_op0 = 0; m_op1 = 0; m_cnt = 0; m_cnt_s = 0;
  endtask

  task automatic idle();
    id_valid = 0; id_opcode = 0; id_rs0 = 0; id_rs1 = 0; id_use_rs0 = 0; id_use_rs1 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; rf_data0 = 0; rf_data1 = 0;
    ex_result = 0; mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_write_en = 0; wb_write_addr = 0; wb_write_data = 0; ex_stall = 0; flush = 0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge
  task automatic step();
    logic lu, st;
    logic [15:0] e0, e1;
    #1;
    lu = id_valid && m_valid && m_mem_read && m_rd != 0 &&
         ((id_use_rs0 && id_rs0 == m_rd) || (id_use_rs1 && id_rs1 == m_rd));
    st = !flush && (ex_stall || lu);
    check("id_stall", id_stall, st);
    check("rf_read0_addr", rf_read0_addr, id_rs0);
    check("rf_read1_addr", rf_read1_addr, id_rs1);
    e0 = pick(id_rs0, rf_data0);
    e1 = pick(id_rs1, rf_data1);
    @(posedge clock);
    #1;
    if (flush || (!ex_stall && lu)) begin
      m_valid = 0;
    end else if (!ex_stall) begin
      m_valid = id_valid; m_opcode = id_opcode; m_rd = id_rd;
      m_reg_write = id_reg_write; m_mem_read = id_mem_read; m_op0 = e0; m_op1 = e1;
    end
    if (st) begin
      m_cnt   = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
      m_cnt_s = (m_cnt_s + 1 > 15) ? 15 : m_cnt_s + 1;
    end
    check("of_valid", of_valid, m_valid);
    if (m_valid) begin
      check("of_opcode", of_opcode, m_opcode);
      check("of_rd", of_rd, m_rd);
      check("of_reg_write", of_reg_write, m_reg_write);
      check("of_mem_read", of_mem_read, m_mem_read);
      check("of_operand0", of_operand0, m_op0);
      check("of_operand1", of_operand1, m_op1);
    end
    check("stall_count", stall_count, m_cnt);
    check("stall_count_w4", s_stall_count, m_cnt_s);
    @(negedge clock);
  endtask

  // Asserted at a falling edge; outputs must clear without waiting for a clock
  task automatic do_reset();
    reset = 0;
    id_valid = 1;
    #1;
    model_reset();
    check("rst_of_valid", of_valid, 0);
    check("rst_stall_count", stall_count, 0);
    check("rst_stall_count_w4", s_stall_count, 0);
    @(posedge clock);
    #1;
    check("rst_hold_valid", of_valid, 0);
    @(negedge clock);
    reset = 1;
    idle();
  endtask

  task automatic capture(input logic [2:0] rd, input logic wr, input logic ld);
    idle();
    id_valid = 1; id_opcode = 4'h5; id_rd = rd; id_reg_write = wr; id_mem_read = ld;
    step();
  endtask

  initial begin
    reset = 0;
    idle();
    repeat (2) @(negedge clock);

    // Reset and release
    do_reset();
    capture(3'd1, 1, 0);
    check("release_capture", of_valid, 1);

    // Forwarding priority on r3
    capture(3'd3, 1, 0);
    idle();
    id_valid = 1; id_rd = 3'd5; id_reg_write = 1; id_rs0 = 3'd3; id_use_rs0 = 1;
    ex_result = 16'h1111; mem_fwd_en = 1; mem_fwd_rd = 3'd3; mem_fwd_data = 16'h2222;
    wb_write_en = 1; wb_write_addr = 3'd3; wb_write_data = 16'h3333; rf_data0 = 16'h4444;
    step();
    check("prio_ex", of_operand0, 16'h1111);
    step();
    check("prio_mem", of_operand0, 16'h2222);
    mem_fwd_en = 0;
    step();
    check("prio_wb", of_operand0, 16'h3333);
    wb_write_en = 0;
    step();
    check("prio_rf", of_operand0, 16'h4444);

    // r0 never forwards; a load to r0 creates no hazard
    capture(3'd0, 1, 0);
    idle();
    id_valid = 1; id_rs1 = 3'd0; id_use_rs1 = 1; ex_result = 16'hFFFF; rf_data1 = 16'hABCD;
    step();
    check("r0_operand1", of_operand1, 16'h0000);
    capture(3'd0, 1, 1);
    idle();
    id_valid = 1; id_rs0 = 3'd0; id_use_rs0 = 1;
    #1;
    check("r0_load_no_stall", id_stall, 0);
    step();

    // Load-use: one bubble, then value arrives from MEM
    do_reset();
    capture(3'd2, 1, 1);
    idle();
    id_valid = 1; id_rs0 = 3'd2; id_use_rs0 = 1; id_rd = 3'd4; id_reg_write = 1;
    ex_result = 16'h0BAD;
    #1;
    check("lu_stall", id_stall, 1);
    step();
    check("lu_bubble", of_valid, 0);
    mem_fwd_en = 1; mem_fwd_rd = 3'd2; mem_fwd_data = 16'hBEEF;
    #1;
    check("lu_resolved", id_stall, 0);
    step();
    check("lu_operand", of_operand0, 16'hBEEF);
    check("lu_count", stall_count, 1);

    // Flush beats ex_stall; ex_stall alone holds the register
    do_reset();
    capture(3'd6, 1, 0);
    idle();
    id_valid = 1; ex_stall = 1; flush = 1;
    #1;
    check("flush_no_stall", id_stall, 0);
    step();
    check("flush_kill", of_valid, 0);
    capture(3'd6, 1, 0);
    idle();
    id_valid = 1; id_rd = 3'd1; ex_stall = 1;
    repeat (3) step();
    check("hold_valid", of_valid, 1);
    check("hold_rd", of_rd, 3'd6);
    check("hold_count", stall_count, 3);

    // Saturation of the 4-bit counter
    do_reset();
    ex_stall = 1;
    repeat (20) step();
    check("sat_w4", s_stall_count, 4'hF);
    check("nosat_w16", stall_count, 20);
    step();
    check("sat_w4_stays", s_stall_count, 4'hF);

    // Random traffic; small index range keeps hazards frequent
    do_reset();
    for (int i = 0; i < 400; i++) begin
      id_valid      = ($urandom_range(0, 3) != 0);
      id_opcode     = 4'($urandom);
      id_rs0        = 3'($urandom_range(0, 3));
      id_rs1        = 3'($urandom_range(0, 3));
      id_use_rs0    = 1'($urandom);
      id_use_rs1    = 1'($urandom);
      id_rd         = 3'($urandom_range(0, 3));
      id_reg_write  = 1'($urandom);
      id_mem_read   = ($urandom_range(0, 2) == 0);
      rf_data0      = 16'($urandom);
      rf_data1      = 16'($urandom);
      ex_result     = 16'($urandom);
      mem_fwd_en    = 1'($urandom);
      mem_fwd_rd    = 3'($urandom_range(0, 3));
      mem_fwd_data  = 16'($urandom);
      wb_write_en   = 1'($urandom);
      wb_write_addr = 3'($urandom_range(0, 3));
      wb_write_data = 16'($urandom);
      ex_stall      = ($urandom_range(0, 5) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      step();
    end

    // Reset asserted while stalled: nothing pending survives
    ex_stall = 1;
    step();
    do_reset();
    capture(3'd2, 1, 0);
    check("post_reset_capture", of_valid, 1);
    check("post_reset_count", stall_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
